// File: rtl/accel_dispatch.sv
// Job dispatcher: routes the DMA input stream to one of NUM_KERNELS kernels and
// returns the selected kernel's results to DMA through a FWFT FIFO, with tlast on the final word.
module accel_dispatch #(
    parameter int NUM_KERNELS = 4,
    parameter int DATA_WIDTH  = 32,
    parameter int FIFO_DEPTH  = 64,
    parameter int CNT_WIDTH   = 16
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_KERNELS-1:0]            ap_start,
    input  logic                              ap_abort,
    output logic                              ap_idle,
    output logic [NUM_KERNELS-1:0]            ap_done,
    output logic                              start_err,
    output logic [CNT_WIDTH-1:0]              words_out,
    input  logic                              ss_tvalid,
    input  logic [DATA_WIDTH-1:0]             ss_tdata,
    input  logic                              ss_tlast,
    output logic                              ss_tready,
    output logic [NUM_KERNELS-1:0]            k_ss_tvalid,
    output logic [NUM_KERNELS*DATA_WIDTH-1:0] k_ss_tdata,
    output logic [NUM_KERNELS-1:0]            k_ss_tlast,
    input  logic [NUM_KERNELS-1:0]            k_ss_tready,
    input  logic [NUM_KERNELS-1:0]            k_out_valid,
    input  logic [NUM_KERNELS*DATA_WIDTH-1:0] k_out_data,
    output logic [NUM_KERNELS-1:0]            k_out_ready,
    input  logic [NUM_KERNELS-1:0]            k_done,
    input  logic                              sm_tready,
    output logic                              sm_tvalid,
    output logic [DATA_WIDTH-1:0]             sm_tdata,
    output logic                              sm_tlast
);

    localparam int AW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

    state_t                  state_q;
    logic [NUM_KERNELS-1:0]  sel_q;
    logic [NUM_KERNELS-1:0]  ap_done_q;
    logic                    start_err_q;
    logic                    ap_idle_q;
    logic [CNT_WIDTH-1:0]    words_q;

    logic [DATA_WIDTH-1:0]   mem_q [FIFO_DEPTH];
    logic [AW-1:0]           wptr_q, rptr_q;
    logic [AW:0]             cnt_q;

    logic                    run, drain, abort, full, push, pop, start_onehot;
    logic [DATA_WIDTH-1:0]   push_data;

    assign run          = (state_q == RUN);
    assign drain        = (state_q == DRAIN);
    assign abort        = ap_abort && (state_q != IDLE);
    assign full         = (cnt_q == (AW+1)'(FIFO_DEPTH));
    assign start_onehot = (ap_start != '0) &&
                          ((ap_start & (ap_start - NUM_KERNELS'(1))) == '0);

    assign ss_tready   = run && |(k_ss_tready & sel_q);
    assign k_ss_tvalid = run ? ({NUM_KERNELS{ss_tvalid}} & sel_q) : '0;
    assign k_ss_tlast  = run ? ({NUM_KERNELS{ss_tlast}} & sel_q) : '0;
    assign k_ss_tdata  = {NUM_KERNELS{ss_tdata}};
    assign k_out_ready = (run && !full && !ap_abort) ? sel_q : '0;

    always_comb begin
        push_data = '0;
        for (int unsigned i = 0; i < NUM_KERNELS; i++) begin
            if (sel_q[i]) push_data = push_data | k_out_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    assign push = |(k_out_valid & k_out_ready);

    // In RUN the newest word is held back so tlast can be attached once done is known.
    always_comb begin
        sm_tvalid = 1'b0;
        if (run)        sm_tvalid = (cnt_q >= (AW+1)'(2));
        else if (drain) sm_tvalid = (cnt_q != '0);
    end

    assign sm_tlast  = drain && (cnt_q == (AW+1)'(1));
    assign sm_tdata  = (cnt_q != '0) ? mem_q[rptr_q] : '0;
    assign pop       = sm_tvalid && sm_tready;

    assign ap_idle   = ap_idle_q;
    assign ap_done   = ap_done_q;
    assign start_err = start_err_q;
    assign words_out = words_q;

    always_ff @(posedge clk) begin
        if (push) mem_q[wptr_q] <= push_data;
    end

    always_ff @(posedge clk) begin
        if (rst || abort) begin
            wptr_q <= '0;
            rptr_q <= '0;
            cnt_q  <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + AW'(1);
            if (pop)  rptr_q <= rptr_q + AW'(1);
            case ({push, pop})
                2'b10:   cnt_q <= cnt_q + (AW+1)'(1);
                2'b01:   cnt_q <= cnt_q - (AW+1)'(1);
                default: cnt_q <= cnt_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            sel_q       <= '0;
            ap_done_q   <= '0;
            start_err_q <= 1'b0;
            ap_idle_q   <= 1'b1;
            words_q     <= '0;
        end else begin
            ap_done_q   <= '0;
            start_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start_onehot) begin
                        sel_q     <= ap_start;
                        words_q   <= '0;
                        state_q   <= RUN;
                        ap_idle_q <= 1'b0;
                    end else if (ap_start != '0) begin
                        start_err_q <= 1'b1;
                        sel_q       <= '0;
                    end
                end
                RUN: begin
                    if (push && words_q != '1) words_q <= words_q + CNT_WIDTH'(1);
                    if (abort) begin
                        state_q   <= IDLE;
                        ap_idle_q <= 1'b1;
                    end else if (|(k_done & sel_q)) begin
                        ap_done_q <= sel_q;
                        state_q   <= DRAIN;
                    end
                end
                DRAIN: begin
                    if (abort || cnt_q == '0 || (pop && sm_tlast)) begin
                        state_q   <= IDLE;
                        ap_idle_q <= 1'b1;
                    end
                end
                default: begin
                    state_q   <= IDLE;
                    ap_idle_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_accel_dispatch.sv
// Directed self-checking bench for accel_dispatch: streaming jobs, backpressure,
// illegal start, zero-word job and abort.
module tb_accel_dispatch;

    localparam int NK = 4;
    localparam int DW = 32;

    logic           clk = 1'b0;
    logic           rst;
    logic [NK-1:0]  ap_start;
    logic           ap_abort;
    logic           ap_idle;
    logic [NK-1:0]  ap_done;
    logic           start_err;
    logic [15:0]    words_out;
    logic           ss_tvalid, ss_tlast, ss_tready;
    logic [DW-1:0]  ss_tdata;
    logic [NK-1:0]  k_ss_tvalid, k_ss_tlast, k_ss_tready;
    logic [NK*DW-1:0] k_ss_tdata;
    logic [NK-1:0]  k_out_valid, k_out_ready, k_done;
    logic [NK*DW-1:0] k_out_data;
    logic           sm_tready, sm_tvalid, sm_tlast;
    logic [DW-1:0]  sm_tdata;

    int n_checks = 0;
    int n_errors = 0;

    accel_dispatch #(.NUM_KERNELS(NK), .DATA_WIDTH(DW), .FIFO_DEPTH(64), .CNT_WIDTH(16)) dut (
        .clk(clk), .rst(rst), .ap_start(ap_start), .ap_abort(ap_abort),
        .ap_idle(ap_idle), .ap_done(ap_done), .start_err(start_err), .words_out(words_out),
        .ss_tvalid(ss_tvalid), .ss_tdata(ss_tdata), .ss_tlast(ss_tlast), .ss_tready(ss_tready),
        .k_ss_tvalid(k_ss_tvalid), .k_ss_tdata(k_ss_tdata), .k_ss_tlast(k_ss_tlast),
        .k_ss_tready(k_ss_tready), .k_out_valid(k_out_valid), .k_out_data(k_out_data),
        .k_out_ready(k_out_ready), .k_done(k_done), .sm_tready(sm_tready),
        .sm_tvalid(sm_tvalid), .sm_tdata(sm_tdata), .sm_tlast(sm_tlast)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] pat(input int k, input int i);
        return {4'hC, 4'(k), 24'(i)};
    endfunction

    // rmode: 0 = sink always ready, 1 = random sink ready, 2 = sink stalled until kernel blocked
    task automatic run_job(input int k, input int n, input int rmode);
        int sent = 0, recv = 0, dones = 0, lasts = 0, cyc = 0, blocked = 0;
        bit done_drv = 0, stalled = 0, blk_seen = 0;
        logic [31:0] held = '0;
        @(negedge clk);
        ap_start = 4'(1 << k);
        @(negedge clk);
        ap_start = '0;
        #1 check("busy_after_start", ap_idle, 0);
        while (cyc < 3000) begin
            case (rmode)
                0:       sm_tready = 1'b1;
                1:       sm_tready = 1'($urandom_range(0, 1));
                default: sm_tready = (blocked >= 4);
            endcase
            k_out_valid = '0;
            k_out_valid[k] = (sent < n);
            k_out_data[k*DW +: DW] = pat(k, sent);
            k_done = '0;
            if (sent == n && !done_drv) begin
                k_done[k] = 1'b1;
                done_drv = 1;
            end
            #1;
            check("kready_unselected", k_out_ready & ~NK'(1 << k), 0);
            if (rmode == 2 && !k_out_ready[k] && sent < n && sent > 0) begin
                if (!blk_seen) begin
                    check("stored_when_full", sent, 64);
                    check("words_when_full", words_out, 64);
                end
                blk_seen = 1;
                blocked++;
            end
            if (stalled) begin
                check("hold_valid", sm_tvalid, 1);
                check("hold_data", sm_tdata, held);
            end
            stalled = sm_tvalid && !sm_tready;
            held = sm_tdata;
            if (k_out_valid[k] && k_out_ready[k]) sent++;
            if (sm_tvalid && sm_tready) begin
                check("beat_data", sm_tdata, pat(k, recv));
                check("beat_tlast", sm_tlast, recv == n - 1);
                lasts += int'(sm_tlast);
                recv++;
            end
            if (ap_done != '0) begin
                dones++;
                check("done_bits", ap_done, 64'(1) << k);
            end
            if (dones > 0 && ap_idle) break;
            @(negedge clk);
            cyc++;
        end
        check("job_timeout", cyc >= 3000, 0);
        check("job_beats", recv, n);
        check("job_done_pulses", dones, 1);
        check("job_tlast_count", lasts, 1);
        check("job_words_out", words_out, n);
        if (rmode == 2) check("job_blocked_seen", blk_seen, 1);
        k_out_valid = '0;
        k_done = '0;
    endtask

    initial begin
        int sent;
        rst = 1'b1;
        ap_start = '0; ap_abort = 1'b0;
        ss_tvalid = 1'b1; ss_tdata = 32'h1234_5678; ss_tlast = 1'b0;
        k_ss_tready = '1; k_out_valid = '0; k_out_data = '0; k_done = '0;
        sm_tready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_idle", ap_idle, 1);
        check("rst_done", ap_done, 0);
        check("rst_err", start_err, 0);
        check("rst_words", words_out, 0);
        check("rst_tvalid", sm_tvalid, 0);
        check("rst_tdata", sm_tdata, 0);
        check("rst_kready", k_out_ready, 0);
        check("rst_ss_tready", ss_tready, 0);

        // Kernel 1, 64 results, sink always ready
        run_job(1, 64, 0);
        check("idle_after_job1", ap_idle, 1);

        // Illegal multi-hot start
        @(negedge clk);
        ap_start = 4'b0110;
        @(negedge clk);
        ap_start = '0;
        #1;
        check("bad_start_err", start_err, 1);
        check("bad_start_idle", ap_idle, 1);
        check("bad_start_ss_tready", ss_tready, 0);
        check("bad_start_kvalid", k_ss_tvalid, 0);
        @(negedge clk);
        #1 check("bad_start_err_pulse", start_err, 0);

        // 70 words into a stalled sink: FIFO fills at 64, then drains fully
        run_job(0, 70, 2);

        // Random sink backpressure
        run_job(3, 10, 1);

        // Zero-word job
        @(negedge clk);
        ap_start = 4'b0100;
        @(negedge clk);
        ap_start = '0;
        #1 check("zw_busy", ap_idle, 0);
        @(negedge clk);
        @(negedge clk);
        k_done = 4'b0100;
        @(negedge clk);
        k_done = '0;
        #1;
        check("zw_done", ap_done, 4'b0100);
        check("zw_drain_busy", ap_idle, 0);
        check("zw_no_beat", sm_tvalid, 0);
        @(negedge clk);
        #1;
        check("zw_idle", ap_idle, 1);
        check("zw_done_cleared", ap_done, 0);

        // Abort with 5 words buffered
        @(negedge clk);
        ap_start = 4'b0100;
        sm_tready = 1'b0;
        @(negedge clk);
        ap_start = '0;
        sent = 0;
        for (int c = 0; c < 50 && sent < 5; c++) begin
            k_out_valid = 4'b0100;
            k_out_data[2*DW +: DW] = pat(2, sent);
            #1;
            if (k_out_ready[2]) sent++;
            if (sent < 5) @(negedge clk);
        end
        @(negedge clk);
        k_out_valid = '0;
        #1;
        check("ab_words", words_out, 5);
        check("ab_valid_before", sm_tvalid, 1);
        ap_abort = 1'b1;
        @(negedge clk);
        ap_abort = 1'b0;
        sm_tready = 1'b1;
        #1;
        check("ab_idle", ap_idle, 1);
        check("ab_flushed_valid", sm_tvalid, 0);
        check("ab_flushed_data", sm_tdata, 0);
        check("ab_no_done", ap_done, 0);
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            #1 check("ab_quiet", {ap_done, sm_tvalid}, 0);
        end
        // Abort in IDLE is ignored; a fresh job runs cleanly
        ap_abort = 1'b1;
        @(negedge clk);
        ap_abort = 1'b0;
        #1 check("ab_idle_ignored", ap_idle, 1);
        run_job(2, 4, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/accel_dispatch.md
Name: accel_dispatch

Overview:
N-kernel job dispatcher for the user-project accelerator. It routes the DMA input AXI-Stream to one of NUM_KERNELS attached kernels, selected by a one-hot ap_start. Kernel results are buffered in a parametrised output FIFO and returned to DMA as AXI-Stream, with a correct sm_tlast on the final word of every job. Unlike the fixed 3-kernel predecessor, it streams results during the run, backpressures kernels when the FIFO is full, supports abort, and flags illegal starts.

Parameters:
NUM_KERNELS, 4, number of attached kernels; must be 2 or more.
DATA_WIDTH, 32, stream and kernel data width.
FIFO_DEPTH, 64, output FIFO entries; power of 2, at least 2.
CNT_WIDTH, 16, width of the per-job output word counter.

Ports:
clk  in  1  clock.
rst  in  1  synchronous reset, active-high.
ap_start  in  NUM_KERNELS  one-hot job start, sampled in IDLE only.
ap_abort  in  1  abort current job.
ap_idle  out  1  high in IDLE.
ap_done  out  NUM_KERNELS  one-cycle pulse on the bit of the finished kernel.
start_err  out  1  one-cycle pulse on an illegal start.
words_out  out  CNT_WIDTH  words written to the FIFO in the current or last job.
ss_tvalid/ss_tdata/ss_tlast  in  1/DATA_WIDTH/1  DMA-to-accelerator stream.
ss_tready  out  1  ready of the selected kernel; 0 when no kernel is selected.
k_ss_tvalid  out  NUM_KERNELS  per-kernel input valid.
k_ss_tdata  out  NUM_KERNELS*DATA_WIDTH  broadcast copy of ss_tdata.
k_ss_tlast  out  NUM_KERNELS  per-kernel input last.
k_ss_tready  in  NUM_KERNELS  per-kernel input ready.
k_out_valid  in  NUM_KERNELS  kernel result valid.
k_out_data  in  NUM_KERNELS*DATA_WIDTH  kernel results; kernel i uses slice [i*DATA_WIDTH +: DATA_WIDTH].
k_out_ready  out  NUM_KERNELS  result accept: high only for the selected kernel while the FIFO is not full.
k_done  in  NUM_KERNELS  kernel completion pulse.
sm_tready  in  1  DMA ready.
sm_tvalid/sm_tdata/sm_tlast  out  1/DATA_WIDTH/1  accelerator-to-DMA stream.

Behaviour:
- Reset values: state IDLE, sel=0, FIFO empty (pointers and count 0), words_out=0, ap_idle=1, all pulses and valids 0, sm_tdata=0. Reset mid-job discards all state.
- State IDLE: ap_idle=1. If ap_start is one-hot, latch sel<=ap_start, clear words_out and go to RUN. If ap_start is nonzero but not one-hot, pulse start_err, stay in IDLE and select nothing.
- State RUN: k_ss_tvalid[i] = ss_tvalid & sel[i]; k_ss_tlast[i] = ss_tlast & sel[i]; ss_tready = |(k_ss_tready & sel).
- RUN, FIFO push: a push happens when k_out_valid and k_out_ready of the selected kernel are both high. Each push increments words_out, which saturates at its maximum value.
- RUN, tail hold-back: sm_tvalid = (count >= 2), so the final word always stays in the FIFO until done is known.
- RUN to DRAIN: on k_done of the selected kernel, pulse ap_done=sel for 1 cycle and go to DRAIN. A push in the same cycle is accepted. k_done from unselected kernels is ignored.
- State DRAIN: no pushes. sm_tvalid = (count != 0). sm_tlast = sm_tvalid & (count == 1).
- DRAIN to IDLE: on the handshake where tlast is asserted, go to IDLE next cycle. If DRAIN is entered with count==0 (zero-word job), go to IDLE after 1 cycle with no beat.
- ap_abort in RUN or DRAIN: flush the FIFO, go to IDLE next cycle, no ap_done. ap_abort in IDLE has no effect.
- FIFO: first-word fall-through; sm_tdata = mem[rptr]. Pop when sm_tvalid & sm_tready.
- FIFO timing: a word pushed at cycle t is visible on sm_tdata at t+1.
- FIFO simultaneous push and pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
- FIFO full: k_out_ready=0 and no overwrite. Empty: no pop and no underflow.
- sm_tvalid/sm_tdata are stable while stalled (sm_tready=0).
- ap_start is ignored outside IDLE.

Test Plan:
- Kernel 1 start (ap_start=4'b0010), 64 results, sm_tready=1 -> 64 beats in order; only beat 64 has sm_tlast=1; ap_done=4'b0010 for 1 cycle; words_out=64; back to IDLE.
- Bad start, ap_start=4'b0110 -> start_err pulses for 1 cycle; ap_idle stays 1; ss_tready=0.
- sm_tready=0 while the kernel offers 70 words -> exactly 64 stored; k_out_ready=0 from then on. Release sm_tready -> all 70 out, no loss, tlast on word 70.
- Random sm_tready toggling with a 10-word job -> data matches input order; sm_tdata is held during stalls; single tlast.
- Zero-word job (k_done 3 cycles after start) -> ap_done pulse, no sm beats, IDLE 2 cycles after done.
- ap_abort with 5 words buffered -> no further beats, no ap_done, FIFO empty, IDLE next cycle. A new start afterwards runs cleanly.
